// File: rtl/ball_attach_if.sv
// Grid RAM port between the attach controller and the playfield store.
// Read data is expected one cycle after the address.
interface ball_attach_if;
  logic [8:0] grid_addr;
  logic [2:0] grid_rdata;
  logic       grid_we;
  logic [2:0] grid_wdata;

  modport master (
    output grid_addr,
    output grid_we,
    output grid_wdata,
    input  grid_rdata
  );

  modport slave (
    input  grid_addr,
    input  grid_we,
    input  grid_wdata,
    output grid_rdata
  );
endinterface

// File: rtl/ball_attach.sv
// Snaps a moving ball into the 20x13 bubble grid once per frame when it touches
// the ceiling or an occupied up/left/right neighbour.
//
// state | meaning
// IDLE  | waiting for a frame tick with the ball inside the grid
// R_TGT | address the target cell
// R_UP  | target data back (occupied -> abort); address up neighbour
// R_LT  | up data back; address left neighbour
// R_RT  | left data back; address right neighbour
// EVAL  | right data back; decide attach
// WRITE | write ball colour, pulse inserted/game_over
// HOLD  | wait for the ball to leave the grid before re-arming
module ball_attach (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic [1:0]    Game_State,
  input  logic [9:0]    ballX,
  input  logic [9:0]    ballY,
  input  logic [1:0]    ballColor,
  ball_attach_if.master gbus,
  output logic          inserted,
  output logic [3:0]    insert_row,
  output logic [4:0]    insert_col,
  output logic          game_over
);

  typedef enum logic [2:0] {
    IDLE, R_TGT, R_UP, R_LT, R_RT, EVAL, WRITE, HOLD
  } state_t;

  state_t     state_q, state_d;
  logic       frame_s1_q, frame_s2_q;
  logic [3:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [1:0] color_q, color_d;
  logic [8:0] tgt_q, tgt_d;
  logic       up_occ_q, up_occ_d;
  logic       left_occ_q, left_occ_d;
  logic [3:0] insert_row_q, insert_row_d;
  logic [4:0] insert_col_q, insert_col_d;

  logic       frame_edge;
  logic       playing;
  logic       in_region;
  logic       start;
  logic       cell_occ;
  logic       right_occ;
  logic       any_occ;
  logic [3:0] ball_row;
  logic [4:0] ball_col;
  logic [8:0] ball_tgt;
  logic [8:0] up_addr;
  logic [8:0] left_addr;
  logic [8:0] right_addr;

  assign frame_edge = frame_s1_q & ~frame_s2_q;
  assign playing    = (Game_State == 2'd1);
  assign in_region  = (ballX < 10'd640) && (ballY < 10'd416);
  assign start      = frame_edge && playing && in_region;
  assign ball_row   = ballY[8:5];
  assign ball_col   = ballX[9:5];
  // row*20 + col as row*16 + row*4 + col
  assign ball_tgt   = {1'b0, ball_row, 4'b0000} + {3'b000, ball_row, 2'b00} + {4'b0000, ball_col};

  assign cell_occ   = (gbus.grid_rdata != 3'd0);
  assign right_occ  = (col_q != 5'd19) && cell_occ;
  assign any_occ    = up_occ_q | left_occ_q | right_occ;

  // Edge cells point back at the target; their data is replaced by fixed values.
  assign up_addr    = (row_q != 4'd0)  ? tgt_q - 9'd20 : tgt_q;
  assign left_addr  = (col_q != 5'd0)  ? tgt_q - 9'd1  : tgt_q;
  assign right_addr = (col_q != 5'd19) ? tgt_q + 9'd1  : tgt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      frame_s1_q   <= 1'b0;
      frame_s2_q   <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      color_q      <= '0;
      tgt_q        <= '0;
      up_occ_q     <= 1'b0;
      left_occ_q   <= 1'b0;
      insert_row_q <= '0;
      insert_col_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_s1_q   <= frame_clk;
      frame_s2_q   <= frame_s1_q;
      row_q        <= row_d;
      col_q        <= col_d;
      color_q      <= color_d;
      tgt_q        <= tgt_d;
      up_occ_q     <= up_occ_d;
      left_occ_q   <= left_occ_d;
      insert_row_q <= insert_row_d;
      insert_col_q <= insert_col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = R_TGT;
      R_TGT:   state_d = R_UP;
      R_UP:    state_d = cell_occ ? IDLE : R_LT;
      R_LT:    state_d = R_RT;
      R_RT:    state_d = EVAL;
      EVAL:    state_d = any_occ ? WRITE : IDLE;
      WRITE:   state_d = HOLD;
      HOLD:    if (!playing || (frame_edge && !in_region)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Leaving play aborts a read sequence; a started write always completes.
    if (!playing && (state_q != WRITE) && (state_q != HOLD)) state_d = IDLE;
  end

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    color_d      = color_q;
    tgt_d        = tgt_q;
    up_occ_d     = up_occ_q;
    left_occ_d   = left_occ_q;
    insert_row_d = insert_row_q;
    insert_col_d = insert_col_q;
    if ((state_q == IDLE) && start) begin
      row_d   = ball_row;
      col_d   = ball_col;
      color_d = ballColor;
      tgt_d   = ball_tgt;
    end
    if (state_q == R_LT) up_occ_d   = (row_q == 4'd0) || cell_occ;
    if (state_q == R_RT) left_occ_d = (col_q != 5'd0) && cell_occ;
    // Loaded on entry to WRITE so the new cell is visible alongside the pulse.
    if ((state_q == EVAL) && (state_d == WRITE)) begin
      insert_row_d = row_q;
      insert_col_d = col_q;
    end
  end

  always_comb begin
    gbus.grid_addr  = '0;
    gbus.grid_we    = 1'b0;
    gbus.grid_wdata = '0;
    inserted        = 1'b0;
    game_over       = 1'b0;
    case (state_q)
      R_TGT: gbus.grid_addr = tgt_q;
      R_UP:  gbus.grid_addr = up_addr;
      R_LT:  gbus.grid_addr = left_addr;
      R_RT:  gbus.grid_addr = right_addr;
      WRITE: begin
        gbus.grid_addr  = tgt_q;
        gbus.grid_we    = 1'b1;
        gbus.grid_wdata = {1'b0, color_q} + 3'd1;
        inserted        = 1'b1;
        game_over       = (row_q == 4'd12);
      end
      default: ;
    endcase
  end

  assign insert_row = insert_row_q;
  assign insert_col = insert_col_q;

endmodule

// File: tb/tb_ball_attach.sv
// Directed bench for ball_attach: a frame-level attach model checks every cycle,
// and literal expectations pin the model on hand-worked placements.
module tb_ball_attach;
  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [1:0] Game_State;
  logic [9:0] ballX, ballY;
  logic [1:0] ballColor;
  logic       inserted, game_over;
  logic [3:0] insert_row;
  logic [4:0] insert_col;

  ball_attach_if gif();

  ball_attach dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .Game_State (Game_State),
    .ballX      (ballX),
    .ballY      (ballY),
    .ballColor  (ballColor),
    .gbus       (gif.master),
    .inserted   (inserted),
    .insert_row (insert_row),
    .insert_col (insert_col),
    .game_over  (game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Frame tick as seen after the two-register edge detector.
  logic s1, s2;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= frame_clk;
      s2 <= s1;
    end
  end

  // Grid RAM: one-cycle read latency.
  logic [2:0] mem [0:259];
  logic       clr_req = 1'b0;
  logic       set_req = 1'b0;
  logic [8:0] set_addr = '0;
  logic [2:0] set_val = '0;
  always @(posedge Clk) begin
    if (clr_req) begin
      for (int i = 0; i < 260; i++) mem[i] <= 3'd0;
    end else if (set_req) begin
      mem[set_addr] <= set_val;
    end else if (gif.grid_we && (gif.grid_addr < 9'd260)) begin
      mem[gif.grid_addr] <= gif.grid_wdata;
    end
    gif.grid_rdata <= (gif.grid_addr < 9'd260) ? mem[gif.grid_addr] : 3'd0;
  end

  // Model state and observations.
  int mgrid [0:259];
  bit busy, holding, will_wr, playing, inreg, edge_now, e_we, e_go;
  int k, m_row, m_col, m_color, m_tgt, e_addr, e_wdata, exp_ir, exp_ic;
  int n_wr, n_ins, n_go, last_waddr, last_wdata, last_wcyc, go_cyc, fe_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic set_ball(input int x, input int y, input int c);
    step();
    ballX = 10'(x);
    ballY = 10'(y);
    ballColor = 2'(c);
  endtask

  task automatic set_cell(input int a, input int v);
    step();
    set_addr = 9'(a);
    set_val = 3'(v);
    set_req = 1'b1;
    step();
    set_req = 1'b0;
  endtask

  task automatic grid_clear();
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  task automatic frame_edge();
    step();
    frame_clk = 1'b1;
    fe_cyc = cyc;
    step();
    frame_clk = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    frame_clk = 1'b0;
    Game_State = 2'd1;
    ballX = 10'd0;
    ballY = 10'd500;
    ballColor = 2'd0;
    n_wr = 0; n_ins = 0; n_go = 0;
    last_waddr = -1; last_wdata = -1; last_wcyc = 0; go_cyc = -1; fe_cyc = 0;
    busy = 0; holding = 0; k = 0; exp_ir = 0; exp_ic = 0;
    for (int i = 0; i < 260; i++) mgrid[i] = 0;

    // Per-cycle model and compare.
    fork
      forever begin
        @(negedge Clk);
        if (!Reset) begin
          busy = 0; holding = 0; k = 0; exp_ir = 0; exp_ic = 0;
        end else begin
          if (clr_req) for (int i = 0; i < 260; i++) mgrid[i] = 0;
          if (set_req) mgrid[set_addr] = set_val;
          playing  = (Game_State == 2'd1);
          inreg    = (ballX < 10'd640) && (ballY < 10'd416);
          edge_now = s1 && !s2;
          e_we = 0; e_go = 0; e_addr = 0; e_wdata = 0;
          if (busy) begin
            k++;
            if (k < 6 && !playing) busy = 0;
            else if (k == 6) begin
              busy = 0;
              if (will_wr) begin
                e_we = 1; e_addr = m_tgt; e_wdata = m_color + 1; e_go = (m_row == 12);
                exp_ir = m_row; exp_ic = m_col;
                mgrid[m_tgt] = m_color + 1;
                holding = 1;
              end
            end
          end else if (holding) begin
            if (!playing || (edge_now && !inreg)) holding = 0;
          end else if (edge_now && playing && inreg) begin
            busy = 1; k = 0;
            m_row = ballY / 10'd32;
            m_col = ballX / 10'd32;
            m_color = ballColor;
            m_tgt = m_row * 20 + m_col;
            will_wr = (mgrid[m_tgt] == 0) &&
                      ((m_row == 0) || (mgrid[m_tgt - 20] != 0) ||
                       ((m_col > 0) && (mgrid[m_tgt - 1] != 0)) ||
                       ((m_col < 19) && (mgrid[m_tgt + 1] != 0)));
          end
          chk("grid_we", gif.grid_we, e_we);
          chk("inserted", inserted, e_we);
          chk("game_over", game_over, e_go);
          chk("insert_row", insert_row, exp_ir);
          chk("insert_col", insert_col, exp_ic);
          if (e_we) begin
            chk("wr_addr", gif.grid_addr, e_addr);
            chk("wr_data", gif.grid_wdata, e_wdata);
          end
          if (gif.grid_we) begin
            n_wr++; last_waddr = gif.grid_addr; last_wdata = gif.grid_wdata; last_wcyc = cyc;
          end
          if (inserted) n_ins++;
          if (game_over) begin n_go++; go_cyc = cyc; end
        end
      end
    join_none

    // Reset state
    settle(2);
    chk("rst_grid_we", gif.grid_we, 0);
    chk("rst_inserted", inserted, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_grid_addr", gif.grid_addr, 0);
    chk("rst_grid_wdata", gif.grid_wdata, 0);
    chk("rst_insert_row", insert_row, 0);
    step();
    Reset = 1'b1;
    grid_clear();

    // Empty grid, ceiling attach at row 0 col 3
    set_ball(100, 10, 2);
    settle(3);
    frame_edge();
    settle(12);
    chk("ceil_writes", n_wr, 1);
    chk("ceil_addr", last_waddr, 3);
    chk("ceil_wdata", last_wdata, 3);
    chk("ceil_latency", last_wcyc - fe_cyc, 7);
    chk("ceil_row", insert_row, 0);
    chk("ceil_col", insert_col, 3);
    chk("ceil_no_go", n_go, 0);

    // Still in region: further frames must not attach again
    frame_edge();
    settle(6);
    frame_edge();
    settle(8);
    chk("hold_no_rewrite", n_wr, 1);
    set_ball(100, 450, 2);
    settle(2);
    frame_edge();
    settle(4);

    // Up neighbour occupied: target r2 c5 -> addr 45
    set_cell(25, 1);
    set_ball(170, 70, 1);
    settle(2);
    frame_edge();
    settle(10);
    chk("up_writes", n_wr, 2);
    chk("up_addr", last_waddr, 45);
    chk("up_wdata", last_wdata, 2);
    chk("up_row", insert_row, 2);
    chk("up_col", insert_col, 5);
    set_ball(170, 450, 1);
    frame_edge();
    settle(4);

    // Mid-grid with no neighbours: nothing happens
    set_ball(300, 200, 0);
    settle(2);
    frame_edge();
    settle(10);
    chk("free_no_write", n_wr, 2);
    chk("free_no_ins", n_ins, 2);

    // Occupied target, twice
    set_cell(129, 2);
    set_cell(109, 1);
    frame_edge();
    settle(8);
    frame_edge();
    settle(8);
    chk("occ_no_write", n_wr, 2);
    chk("occ_no_ins", n_ins, 2);

    // Bottom row attach -> game_over with inserted
    set_cell(223, 4);
    set_ball(100, 400, 3);
    settle(2);
    frame_edge();
    settle(10);
    chk("bot_writes", n_wr, 3);
    chk("bot_addr", last_waddr, 243);
    chk("bot_wdata", last_wdata, 4);
    chk("bot_go_count", n_go, 1);
    chk("bot_go_cycle", go_cyc, last_wcyc);
    chk("bot_row", insert_row, 12);
    chk("bot_col", insert_col, 3);
    step();
    Game_State = 2'd0;
    settle(3);
    Game_State = 2'd1;
    settle(2);

    // Second frame tick during the read sequence is ignored
    set_cell(52, 1);
    set_ball(400, 100, 0);
    settle(2);
    step();
    frame_clk = 1'b1;
    fe_cyc = cyc;
    step();
    frame_clk = 1'b0;
    step();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    settle(10);
    chk("busy_writes", n_wr, 4);
    chk("busy_addr", last_waddr, 72);
    chk("busy_latency", last_wcyc - fe_cyc, 7);
    set_ball(400, 450, 0);
    frame_edge();
    settle(4);

    // Leaving play mid-sequence aborts
    set_cell(55, 1);
    set_ball(500, 100, 1);
    settle(2);
    frame_edge();
    step();
    Game_State = 2'd0;
    step();
    Game_State = 2'd1;
    settle(10);
    chk("gs_abort_no_write", n_wr, 4);

    // Reset during the left-neighbour read
    step();
    frame_clk = 1'b1;
    fe_cyc = cyc;
    step();
    frame_clk = 1'b0;
    settle(3);
    chk("rlt_left_addr", gif.grid_addr, 74);
    Reset = 1'b0;
    #1;
    chk("mid_rst_we", gif.grid_we, 0);
    chk("mid_rst_ins", inserted, 0);
    chk("mid_rst_addr", gif.grid_addr, 0);
    chk("mid_rst_wdata", gif.grid_wdata, 0);
    chk("mid_rst_row", insert_row, 0);
    chk("mid_rst_col", insert_col, 0);
    settle(3);
    Reset = 1'b1;
    settle(10);
    chk("mid_rst_no_write", n_wr, 4);
    frame_edge();
    settle(10);
    chk("post_rst_writes", n_wr, 5);
    chk("post_rst_addr", last_waddr, 75);
    chk("post_rst_wdata", last_wdata, 2);
    chk("post_rst_latency", last_wcyc - fe_cyc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
